// File: rtl/rt_cnt_pkg.sv
// Shared counter encodings and the binary-to-Gray helper
// used by rt_gray_cnt and other pointer blocks.
package rt_cnt_pkg;

  localparam logic RT_CNT_INC = 1'b0;
  localparam logic RT_CNT_DEC = 1'b1;

  localparam int RT_CNT_WRAP = 0;
  localparam int RT_CNT_SAT  = 1;

  function automatic logic [31:0] rt_bin2gray_f(
    input logic [31:0] bin
  );
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/rt_bin2gray.sv
// Combinational binary-to-Gray converter,
// applied ahead of the Gray register.
module rt_bin2gray #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/rt_gray_cnt.sv
// Binary/Gray up-down counter with clear, set, load,
// enable and optional saturation; all outputs registered.
module rt_gray_cnt
  import rt_cnt_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               SATURATE = 0,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             rt_i_clk,
  input  logic             rt_i_rst_n,
  input  logic             rt_i_clr,
  input  logic             rt_i_set,
  input  logic             rt_i_ld,
  input  logic [WIDTH-1:0] rt_i_ld_val,
  input  logic             rt_i_ce,
  input  logic             rt_i_inc_n,
  output logic [WIDTH-1:0] rt_o_bin_cnt,
  output logic [WIDTH-1:0] rt_o_gray_cnt,
  output logic             rt_o_eqnz,
  output logic             rt_o_tc
);

  localparam bit SAT = (SATURATE == RT_CNT_SAT);
  localparam logic [WIDTH-1:0] RST_GRAY =
    RST_VAL ^ (RST_VAL >> 1);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] next_bin;
  logic [WIDTH-1:0] next_gray;
  logic             next_tc;
  logic             at_max;
  logic             at_min;

  assign at_max = &bin_q;
  assign at_min = ~|bin_q;

  always_comb begin
    next_bin = bin_q;
    next_tc  = 1'b0;
    if (rt_i_clr) begin
      next_bin = RST_VAL;
    end else if (rt_i_set) begin
      next_bin = '1;
    end else if (rt_i_ld) begin
      next_bin = rt_i_ld_val;
    end else if (rt_i_ce) begin
      if (rt_i_inc_n == RT_CNT_INC) begin
        next_tc  = at_max;
        next_bin = (at_max && SAT) ? bin_q
                                   : bin_q + WIDTH'(1);
      end else begin
        next_tc  = at_min;
        next_bin = (at_min && SAT) ? bin_q
                                   : bin_q - WIDTH'(1);
      end
    end
  end

  rt_bin2gray #(
    .WIDTH(WIDTH)
  ) u_b2g (
    .bin (next_bin),
    .gray(next_gray)
  );

  // Gray comes from next_bin so it changes on the same edge as bin.
  always_ff @(posedge rt_i_clk or negedge rt_i_rst_n) begin
    if (!rt_i_rst_n) begin
      bin_q         <= RST_VAL;
      rt_o_gray_cnt <= RST_GRAY;
      rt_o_eqnz     <= (RST_VAL != '0);
      rt_o_tc       <= 1'b0;
    end else begin
      bin_q         <= next_bin;
      rt_o_gray_cnt <= next_gray;
      rt_o_eqnz     <= (next_bin != '0);
      rt_o_tc       <= next_tc;
    end
  end

  assign rt_o_bin_cnt = bin_q;

endmodule

// File: tb/tb_rt_gray_cnt.sv
// Scoreboard bench for rt_gray_cnt over four
// parameterisations sharing one clock and reset.
module tb_rt_gray_cnt;

  typedef struct {
    int          dut;
    logic [31:0] bin;
    logic [31:0] gray;
    logic        nz;
    logic        tc;
    string       name;
  } exp_t;

  logic tb_r_clk;
  logic rst_n;
  logic [3:0] clr, set, ld, ce, inc_n;
  logic [31:0] ld_val [4];

  logic [3:0]  bin0, gray0, bin1, gray1;
  logic [7:0]  bin2, gray2;
  logic [31:0] bin3, gray3;
  logic        nz0, nz1, nz2, nz3;
  logic        tc0, tc1, tc2, tc3;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  logic [3:0] g4 [16] = '{4'h0, 4'h1, 4'h3, 4'h2,
                         4'h6, 4'h7, 4'h5, 4'h4,
                         4'hC, 4'hD, 4'hF, 4'hE,
                         4'hA, 4'hB, 4'h9, 4'h8};

  rt_gray_cnt #(.WIDTH(4), .SATURATE(0), .RST_VAL(4'h0)) u_w4 (
    .rt_i_clk(tb_r_clk), .rt_i_rst_n(rst_n),
    .rt_i_clr(clr[0]), .rt_i_set(set[0]), .rt_i_ld(ld[0]),
    .rt_i_ld_val(ld_val[0][3:0]), .rt_i_ce(ce[0]),
    .rt_i_inc_n(inc_n[0]), .rt_o_bin_cnt(bin0),
    .rt_o_gray_cnt(gray0), .rt_o_eqnz(nz0), .rt_o_tc(tc0));

  rt_gray_cnt #(.WIDTH(4), .SATURATE(1), .RST_VAL(4'h0)) u_s4 (
    .rt_i_clk(tb_r_clk), .rt_i_rst_n(rst_n),
    .rt_i_clr(clr[1]), .rt_i_set(set[1]), .rt_i_ld(ld[1]),
    .rt_i_ld_val(ld_val[1][3:0]), .rt_i_ce(ce[1]),
    .rt_i_inc_n(inc_n[1]), .rt_o_bin_cnt(bin1),
    .rt_o_gray_cnt(gray1), .rt_o_eqnz(nz1), .rt_o_tc(tc1));

  rt_gray_cnt #(.WIDTH(8), .SATURATE(0), .RST_VAL(8'h3C)) u_w8 (
    .rt_i_clk(tb_r_clk), .rt_i_rst_n(rst_n),
    .rt_i_clr(clr[2]), .rt_i_set(set[2]), .rt_i_ld(ld[2]),
    .rt_i_ld_val(ld_val[2][7:0]), .rt_i_ce(ce[2]),
    .rt_i_inc_n(inc_n[2]), .rt_o_bin_cnt(bin2),
    .rt_o_gray_cnt(gray2), .rt_o_eqnz(nz2), .rt_o_tc(tc2));

  rt_gray_cnt #(.WIDTH(32), .SATURATE(0), .RST_VAL(32'h0)) u_w32 (
    .rt_i_clk(tb_r_clk), .rt_i_rst_n(rst_n),
    .rt_i_clr(clr[3]), .rt_i_set(set[3]), .rt_i_ld(ld[3]),
    .rt_i_ld_val(ld_val[3]), .rt_i_ce(ce[3]),
    .rt_i_inc_n(inc_n[3]), .rt_o_bin_cnt(bin3),
    .rt_o_gray_cnt(gray3), .rt_o_eqnz(nz3), .rt_o_tc(tc3));

  initial begin
    tb_r_clk = 1'b0;
    forever #5 tb_r_clk = ~tb_r_clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1);
  end

  always @(negedge tb_r_clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] ab, ag;
      logic an, at;
      e = q.pop_front();
      case (e.dut)
        0: begin ab = 32'(bin0); ag = 32'(gray0); an = nz0; at = tc0; end
        1: begin ab = 32'(bin1); ag = 32'(gray1); an = nz1; at = tc1; end
        2: begin ab = 32'(bin2); ag = 32'(gray2); an = nz2; at = tc2; end
        default: begin ab = bin3; ag = gray3; an = nz3; at = tc3; end
      endcase
      checks++;
      if (ab !== e.bin || ag !== e.gray ||
          an !== e.nz || at !== e.tc) begin
        errors++;
        $display("FAIL %s: dut%0d got bin=%h gray=%h eqnz=%b tc=%b, required bin=%h gray=%h eqnz=%b tc=%b",
                 e.name, e.dut, ab, ag, an, at,
                 e.bin, e.gray, e.nz, e.tc);
      end
    end
  end

  task automatic expect_out(input int d, input logic [31:0] b,
                            input logic [31:0] g, input logic nz,
                            input logic tc, input string nm);
    exp_t e;
    e.dut = d; e.bin = b; e.gray = g;
    e.nz = nz; e.tc = tc; e.name = nm;
    q.push_back(e);
  endtask

  task automatic step(input int d, input logic c, input logic s,
                      input logic l, input logic [31:0] v,
                      input logic e, input logic dn);
    @(negedge tb_r_clk);
    clr = '0; set = '0; ld = '0; ce = '0; inc_n = '0;
    clr[d] = c; set[d] = s; ld[d] = l;
    ld_val[d] = v; ce[d] = e; inc_n[d] = dn;
    @(posedge tb_r_clk);
  endtask

  initial begin
    rst_n = 1'b0;
    clr = '0; set = '0; ld = '0; ce = '0; inc_n = '0;
    for (int i = 0; i < 4; i++) ld_val[i] = '0;
    #1;
    expect_out(0, 32'h0, 32'h0, 1'b0, 1'b0, "reset_w4");
    expect_out(1, 32'h0, 32'h0, 1'b0, 1'b0, "reset_s4");
    expect_out(2, 32'h3C, 32'h22, 1'b1, 1'b0, "reset_w8");
    expect_out(3, 32'h0, 32'h0, 1'b0, 1'b0, "reset_w32");
    @(negedge tb_r_clk);
    rst_n = 1'b1;

    // up-count through the wrap
    for (int k = 1; k <= 17; k++) begin
      step(0, 0, 0, 0, 0, 1, 0);
      expect_out(0, 32'(k % 16), 32'(g4[k % 16]),
                 (k % 16) != 0, k == 16, "upcount");
    end
    step(0, 0, 0, 0, 0, 0, 0);
    expect_out(0, 32'h1, 32'h1, 1'b1, 1'b0, "hold_w4");

    // down-wrap
    step(0, 0, 0, 1, 32'h1, 0, 0);
    expect_out(0, 32'h1, 32'h1, 1'b1, 1'b0, "ld_one");
    step(0, 0, 0, 0, 0, 1, 1);
    expect_out(0, 32'h0, 32'h0, 1'b0, 1'b0, "dec_to0");
    step(0, 0, 0, 0, 0, 1, 1);
    expect_out(0, 32'hF, 32'h8, 1'b1, 1'b1, "dec_wrap");
    step(0, 0, 0, 0, 0, 1, 1);
    expect_out(0, 32'hE, 32'h9, 1'b1, 1'b0, "dec_14");

    // saturation
    step(1, 0, 1, 0, 0, 0, 0);
    expect_out(1, 32'hF, 32'h8, 1'b1, 1'b0, "sat_set");
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 0, 1, 0);
      expect_out(1, 32'hF, 32'h8, 1'b1, 1'b1, "sat_hi");
    end
    step(1, 1, 0, 0, 0, 0, 0);
    expect_out(1, 32'h0, 32'h0, 1'b0, 1'b0, "sat_clr");
    step(1, 0, 0, 0, 0, 1, 1);
    expect_out(1, 32'h0, 32'h0, 1'b0, 1'b1, "sat_lo");
    step(1, 0, 0, 0, 0, 1, 0);
    expect_out(1, 32'h1, 32'h1, 1'b1, 1'b0, "sat_up");

    // priority
    step(2, 1, 1, 1, 32'h5A, 1, 0);
    expect_out(2, 32'h3C, 32'h22, 1'b1, 1'b0, "prio_clr");
    step(2, 0, 1, 1, 32'h5A, 0, 0);
    expect_out(2, 32'hFF, 32'h80, 1'b1, 1'b0, "prio_set");
    step(2, 0, 0, 1, 32'h5A, 1, 0);
    expect_out(2, 32'h5A, 32'h77, 1'b1, 1'b0, "prio_ld");
    step(2, 0, 0, 1, 32'hFF, 1, 0);
    expect_out(2, 32'hFF, 32'h80, 1'b1, 1'b0, "ld_max_no_tc");
    step(2, 0, 0, 0, 0, 1, 0);
    expect_out(2, 32'h0, 32'h0, 1'b0, 1'b1, "w8_wrap");
    step(2, 0, 0, 0, 0, 0, 0);
    expect_out(2, 32'h0, 32'h0, 1'b0, 1'b0, "tc_one_cycle");
    step(2, 0, 0, 0, 0, 1, 1);
    expect_out(2, 32'hFF, 32'h80, 1'b1, 1'b1, "w8_dec_wrap");

    // async reset mid-count
    step(3, 0, 0, 1, 32'h1230, 0, 0);
    expect_out(3, 32'h1230, 32'h1B28, 1'b1, 1'b0, "ld_1230");
    step(3, 0, 0, 0, 0, 1, 0);
    expect_out(3, 32'h1231, 32'h1B29, 1'b1, 1'b0, "cnt_1231");
    step(3, 0, 0, 0, 0, 1, 0);
    expect_out(3, 32'h1232, 32'h1B2B, 1'b1, 1'b0, "cnt_1232");
    step(3, 0, 0, 0, 0, 1, 0);
    expect_out(3, 32'h1233, 32'h1B2A, 1'b1, 1'b0, "cnt_1233");
    step(3, 0, 0, 0, 0, 1, 0);
    expect_out(3, 32'h1234, 32'h1B2E, 1'b1, 1'b0, "cnt_1234");
    step(3, 0, 0, 0, 0, 1, 0);
    #2;
    rst_n = 1'b0;
    expect_out(3, 32'h0, 32'h0, 1'b0, 1'b0, "async_rst");
    @(negedge tb_r_clk);
    @(negedge tb_r_clk);
    ce = '0;
    rst_n = 1'b1;

    // hold at all-ones
    step(3, 0, 0, 1, 32'hFFFF_FFFF, 0, 0);
    expect_out(3, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, "ld_max32");
    for (int k = 0; k < 10; k++) begin
      step(3, 0, 0, 0, 0, 0, 0);
      expect_out(3, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, "hold32");
    end
    step(3, 0, 0, 0, 0, 1, 0);
    expect_out(3, 32'h0, 32'h0, 1'b0, 1'b1, "w32_wrap");

    repeat (3) @(posedge tb_r_clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries unchecked, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
